// File: rtl/spilled_rr_arb_tree.sv
// N-to-1 valid/ready merge: each input is cut by a 2-slot spill register,
// then a lock-in round-robin arbiter picks one spilled stream per cycle.
module spilled_rr_arb_tree #(
    parameter  int NUM_IN     = 4,
    parameter  int DATA_WIDTH = 32,
    localparam int IDX_W      = (NUM_IN > 1) ? $clog2(NUM_IN) : 1
) (
    input  logic                                 clk_i,
    input  logic                                 rst_ni,
    input  logic [NUM_IN-1:0]                    in_valid_i,
    output logic [NUM_IN-1:0]                    in_ready_o,
    input  logic [NUM_IN-1:0][DATA_WIDTH-1:0]    in_data_i,
    output logic                                 out_valid_o,
    input  logic                                 out_ready_i,
    output logic [DATA_WIDTH-1:0]                out_data_o,
    output logic [IDX_W-1:0]                     out_idx_o
);

    logic [NUM_IN-1:0]                 r_a_full, r_b_full;
    logic [NUM_IN-1:0][DATA_WIDTH-1:0] r_a_data, r_b_data;
    logic [NUM_IN-1:0]                 w_a_fill, w_a_drain, w_b_fill, w_b_drain;
    logic [NUM_IN-1:0]                 w_a_full_nxt, w_b_full_nxt;
    logic [NUM_IN-1:0]                 w_spill_valid, w_spill_ready;
    logic [NUM_IN-1:0][DATA_WIDTH-1:0] w_spill_data;

    logic [IDX_W-1:0] r_ptr, r_lock_idx;
    logic             r_lock;
    logic [IDX_W-1:0] w_rr_idx, w_grant, w_ptr_nxt;
    logic             w_hs;

    // Spill stage: B always holds the older beat, so it is presented first.
    assign in_ready_o    = ~r_a_full | ~r_b_full;
    assign w_a_fill      = in_valid_i & in_ready_o;
    assign w_a_drain     = r_a_full & ~r_b_full;
    assign w_b_fill      = w_a_drain & ~w_spill_ready;
    assign w_b_drain     = r_b_full & w_spill_ready;
    assign w_a_full_nxt  = w_a_fill | (r_a_full & ~w_a_drain);
    assign w_b_full_nxt  = w_b_fill | (r_b_full & ~w_b_drain);
    assign w_spill_valid = r_a_full | r_b_full;

    for (genvar g = 0; g < NUM_IN; g++) begin : g_lane
        assign w_spill_data[g]  = r_b_full[g] ? r_b_data[g] : r_a_data[g];
        assign w_spill_ready[g] = out_ready_i && (w_grant == IDX_W'(g));
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_a_full <= '0;
            r_b_full <= '0;
        end else begin
            r_a_full <= w_a_full_nxt;
            r_b_full <= w_b_full_nxt;
        end
    end

    always_ff @(posedge clk_i) begin
        for (int i = 0; i < NUM_IN; i++) begin
            if (w_a_fill[i]) r_a_data[i] <= in_data_i[i];
            if (w_b_fill[i]) r_b_data[i] <= r_a_data[i];
        end
    end

    // Arbiter stage: first valid lane at or after the pointer, wrapping.
    always_comb begin : p_rr
        logic             v_found;
        logic [IDX_W-1:0] v_j;
        v_found  = 1'b0;
        v_j      = '0;
        w_rr_idx = r_ptr;
        for (int k = 0; k < NUM_IN; k++) begin
            v_j = IDX_W'((int'(r_ptr) + k) % NUM_IN);
            if (!v_found && w_spill_valid[v_j]) begin
                v_found  = 1'b1;
                w_rr_idx = v_j;
            end
        end
    end

    assign w_grant     = r_lock ? r_lock_idx : w_rr_idx;
    assign out_valid_o = |w_spill_valid;
    assign out_idx_o   = w_grant;
    assign out_data_o  = out_valid_o ? w_spill_data[w_grant] : '0;
    assign w_hs        = out_valid_o && out_ready_i;
    assign w_ptr_nxt   = (int'(w_grant) == NUM_IN - 1) ? '0 : w_grant + 1'b1;

    // A stalled offer is pinned until accepted so the beat cannot be swapped.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_ptr      <= '0;
            r_lock     <= 1'b0;
            r_lock_idx <= '0;
        end else if (w_hs) begin
            r_ptr  <= w_ptr_nxt;
            r_lock <= 1'b0;
        end else if (out_valid_o) begin
            r_lock     <= 1'b1;
            r_lock_idx <= w_grant;
        end
    end

endmodule

// File: tb/tb_spilled_rr_arb_tree.sv
// Bench for spilled_rr_arb_tree: directed vector table, hand sequences for
// lock-in and async reset, and random traffic against a queue-based model.
module tb_spilled_rr_arb_tree;

    localparam int N  = 4;
    localparam int DW = 32;

    logic                 clk;
    logic                 rst_n;
    logic [N-1:0]         in_valid;
    logic [N-1:0]         in_ready;
    logic [N-1:0][DW-1:0] in_data;
    logic                 out_valid;
    logic                 out_ready;
    logic [DW-1:0]        out_data;
    logic [1:0]           out_idx;

    int total;
    int bad;

    spilled_rr_arb_tree #(.NUM_IN(N), .DATA_WIDTH(DW)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in_data_i   (in_data),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_data_o  (out_data),
        .out_idx_o   (out_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  vin;
        logic [27:0] din;
        logic        ordy;
        logic        evld;
        logic [1:0]  eidx;
        logic [31:0] edata;
        logic [3:0]  erdy;
    } vec_t;

    vec_t tbl[15];

    // Reference model: one bounded FIFO per input plus arbiter bookkeeping.
    logic [31:0] mq [N][$];
    int          m_ptr;
    bit          m_lock;
    int          m_lidx;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic expect_out(input string nm, input logic vld, input logic [1:0] idx,
                              input logic [31:0] data, input logic [3:0] rdy);
        chk({nm, "_valid"}, 32'(out_valid), 32'(vld));
        chk({nm, "_idx"}, 32'(out_idx), 32'(idx));
        chk({nm, "_data"}, out_data, data);
        chk({nm, "_in_ready"}, 32'(in_ready), 32'(rdy));
    endtask

    task automatic set_in(input logic [3:0] vin, input logic [27:0] din, input logic ordy);
        in_valid  = vin;
        out_ready = ordy;
        for (int i = 0; i < N; i++) in_data[i] = {4'(i), din};
    endtask

    task automatic cyc(input logic [3:0] vin, input logic [27:0] din, input logic ordy);
        set_in(vin, din, ordy);
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) mq[i].delete();
        m_ptr  = 0;
        m_lock = 1'b0;
        m_lidx = 0;
    endtask

    task automatic do_reset();
        set_in(4'b0000, 28'h0, 1'b0);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        model_reset();
    endtask

    function automatic bit m_any();
        for (int i = 0; i < N; i++) if (mq[i].size() > 0) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int m_grant();
        if (m_lock) return m_lidx;
        for (int k = 0; k < N; k++)
            if (mq[(m_ptr + k) % N].size() > 0) return (m_ptr + k) % N;
        return m_ptr;
    endfunction

    function automatic logic [3:0] m_ready();
        logic [3:0] r;
        for (int i = 0; i < N; i++) r[i] = (mq[i].size() < 2);
        return r;
    endfunction

    task automatic model_step(input logic [3:0] vin, input logic [27:0] din, input logic ordy);
        int         g;
        bit         v;
        logic [3:0] push;
        g    = m_grant();
        v    = m_any();
        push = vin & m_ready();
        if (v && ordy) begin
            void'(mq[g].pop_front());
            m_ptr  = (g + 1) % N;
            m_lock = 1'b0;
        end else if (v) begin
            m_lock = 1'b1;
            m_lidx = g;
        end
        for (int i = 0; i < N; i++)
            if (push[i]) mq[i].push_back({4'(i), din});
    endtask

    initial begin
        logic [3:0]  rv;
        logic [27:0] rd;
        logic        ro;
        logic [31:0] exp_data;
        int          g;

        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        set_in(4'b0000, 28'h0, 1'b0);

        //           vin      din     ordy  vld   idx   data           rdy
        tbl[0]  = '{4'b0001, 28'hA5, 1'b1, 1'b1, 2'd0, 32'h0000_00A5, 4'b1111};
        tbl[1]  = '{4'b0000, 28'h00, 1'b1, 1'b0, 2'd1, 32'h0000_0000, 4'b1111};
        tbl[2]  = '{4'b0100, 28'h01, 1'b0, 1'b1, 2'd2, 32'h2000_0001, 4'b1111};
        tbl[3]  = '{4'b0100, 28'h02, 1'b0, 1'b1, 2'd2, 32'h2000_0001, 4'b1011};
        tbl[4]  = '{4'b0100, 28'h03, 1'b0, 1'b1, 2'd2, 32'h2000_0001, 4'b1011};
        tbl[5]  = '{4'b0100, 28'h03, 1'b1, 1'b1, 2'd2, 32'h2000_0002, 4'b1111};
        tbl[6]  = '{4'b0100, 28'h03, 1'b1, 1'b1, 2'd2, 32'h2000_0003, 4'b1111};
        tbl[7]  = '{4'b0000, 28'h00, 1'b1, 1'b0, 2'd3, 32'h0000_0000, 4'b1111};
        tbl[8]  = '{4'b1111, 28'h10, 1'b1, 1'b1, 2'd3, 32'h3000_0010, 4'b1111};
        tbl[9]  = '{4'b1111, 28'h11, 1'b1, 1'b1, 2'd0, 32'h0000_0010, 4'b1000};
        tbl[10] = '{4'b1111, 28'h12, 1'b1, 1'b1, 2'd1, 32'h1000_0010, 4'b0001};
        tbl[11] = '{4'b1111, 28'h13, 1'b1, 1'b1, 2'd2, 32'h2000_0010, 4'b0010};
        tbl[12] = '{4'b0000, 28'h00, 1'b1, 1'b1, 2'd3, 32'h3000_0011, 4'b0110};
        tbl[13] = '{4'b0000, 28'h00, 1'b1, 1'b1, 2'd0, 32'h0000_0011, 4'b1110};
        tbl[14] = '{4'b0000, 28'h00, 1'b1, 1'b1, 2'd1, 32'h1000_0011, 4'b1111};

        do_reset();
        expect_out("reset", 1'b0, 2'd0, 32'h0, 4'b1111);

        for (int r = 0; r < 15; r++) begin
            cyc(tbl[r].vin, tbl[r].din, tbl[r].ordy);
            expect_out($sformatf("vec%0d", r), tbl[r].evld, tbl[r].eidx, tbl[r].edata, tbl[r].erdy);
        end

        // Lock-in: a stalled grant on input 3 must survive input 0 arriving.
        do_reset();
        cyc(4'b1000, 28'hD3, 1'b0);
        expect_out("lock_a", 1'b1, 2'd3, 32'h3000_00D3, 4'b1111);
        cyc(4'b0001, 28'hE0, 1'b0);
        expect_out("lock_b", 1'b1, 2'd3, 32'h3000_00D3, 4'b1111);
        cyc(4'b0000, 28'h00, 1'b0);
        expect_out("lock_c", 1'b1, 2'd3, 32'h3000_00D3, 4'b1111);
        cyc(4'b0000, 28'h00, 1'b1);
        expect_out("lock_next", 1'b1, 2'd0, 32'h0000_00E0, 4'b1111);
        cyc(4'b0000, 28'h00, 1'b1);
        expect_out("lock_empty", 1'b0, 2'd1, 32'h0, 4'b1111);

        // Async reset while input 1 is stalled with both slots full.
        cyc(4'b0010, 28'h77, 1'b0);
        cyc(4'b0010, 28'h78, 1'b0);
        expect_out("pre_rst", 1'b1, 2'd1, 32'h1000_0077, 4'b1101);
        set_in(4'b0000, 28'h0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        expect_out("async_rst", 1'b0, 2'd0, 32'h0, 4'b1111);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        for (int k = 0; k < 3; k++) begin
            cyc(4'b0000, 28'h0, 1'b1);
            chk($sformatf("no_stale%0d", k), 32'(out_valid), 32'd0);
        end

        // Random traffic with alternating backpressure intensity.
        do_reset();
        for (int c = 0; c < 2000; c++) begin
            g        = m_grant();
            exp_data = m_any() ? mq[g][0] : 32'h0;
            chk("rnd_valid", 32'(out_valid), 32'(m_any()));
            chk("rnd_idx", 32'(out_idx), 32'(g));
            chk("rnd_data", out_data, exp_data);
            chk("rnd_in_ready", 32'(in_ready), 32'(m_ready()));
            rv = 4'($urandom);
            rd = 28'($urandom);
            case ((c / 64) % 3)
                0:       ro = 1'b1;
                1:       ro = ($urandom_range(0, 1) == 1);
                default: ro = ($urandom_range(0, 9) == 0);
            endcase
            model_step(rv, rd, ro);
            cyc(rv, rd, ro);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
